// File: rtl/dct8_params.sv
// Shared constants for the DCT-8 datapath: default sample width, butterfly
// pairing-mode encodings and saturation limits.
package dct8_params;

    localparam int DCT8_IN_W = 16;

    localparam logic BFLY_MODE_MIRROR = 1'b0;
    localparam logic BFLY_MODE_ADJ    = 1'b1;

    localparam logic [DCT8_IN_W-1:0] DCT8_SAT_MAX = {1'b0, {(DCT8_IN_W-1){1'b1}}};
    localparam logic [DCT8_IN_W-1:0] DCT8_SAT_MIN = {1'b1, {(DCT8_IN_W-1){1'b0}}};

endpackage

// File: rtl/bfly_lane_scale.sv
// One butterfly output lane: arithmetic right shift of a DATA_W+1-bit value,
// then narrowing to DATA_W bits by saturation or wrap, with an overflow flag.
module bfly_lane_scale
    import dct8_params::*;
#(
    parameter int DATA_W  = DCT8_IN_W,
    parameter int SHIFT_W = 2,
    parameter int SAT_EN  = 1
) (
    input  logic [DATA_W:0]    val,
    input  logic [SHIFT_W-1:0] shift,
    output logic [DATA_W-1:0]  res,
    output logic               ovf
);

    logic signed [DATA_W:0] shifted;
    logic [DATA_W-1:0]      sat_max;
    logic [DATA_W-1:0]      sat_min;

    assign sat_max = {1'b0, {(DATA_W-1){1'b1}}};
    assign sat_min = {1'b1, {(DATA_W-1){1'b0}}};

    always_comb begin
        shifted = $signed(val) >>> shift;
        // The value fits DATA_W bits exactly when the two top bits agree.
        ovf = shifted[DATA_W] ^ shifted[DATA_W-1];
        res = shifted[DATA_W-1:0];
        if (ovf && (SAT_EN != 0)) begin
            res = shifted[DATA_W] ? sat_min : sat_max;
        end
    end

endmodule

// File: rtl/dct_butterfly_stage.sv
// N-point butterfly stage: N/2 parallel sum/diff lanes with selectable pairing,
// run-time scaling, saturate-or-wrap narrowing, 2-stage pipeline and overflow stats.
module dct_butterfly_stage
    import dct8_params::*;
#(
    parameter int DATA_W  = DCT8_IN_W,
    parameter int N       = 8,
    parameter int SHIFT_W = 2,
    parameter int SAT_EN  = 1,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*DATA_W-1:0]   in_data,
    input  logic                  mode,
    input  logic [SHIFT_W-1:0]    shift,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N/2*DATA_W-1:0] out_sum,
    output logic [N/2*DATA_W-1:0] out_diff,
    output logic [N/2-1:0]        ovf_lane,
    output logic                  ovf_sticky,
    output logic [CNT_W-1:0]      ovf_count,
    input  logic                  ovf_clr
);

    localparam int H = N / 2;

    logic [DATA_W-1:0]  x        [N];
    logic [DATA_W:0]    pre_sum  [H];
    logic [DATA_W:0]    pre_diff [H];
    logic [DATA_W:0]    s1_sum   [H];
    logic [DATA_W:0]    s1_diff  [H];
    logic [SHIFT_W-1:0] s1_shift;
    logic               s1_valid;
    logic               s2_ready;
    logic [DATA_W-1:0]  sc_sum   [H];
    logic [DATA_W-1:0]  sc_diff  [H];
    logic [H-1:0]       sc_ovf_s;
    logic [H-1:0]       sc_ovf_d;
    logic [H-1:0]       lane_ovf;
    logic               stat_event;
    logic               sticky_base;
    logic [CNT_W-1:0]   cnt_base;
    logic [CNT_W-1:0]   cnt_next;

    for (genvar k = 0; k < N; k++) begin : g_unpack
        assign x[k] = in_data[k*DATA_W +: DATA_W];
    end

    for (genvar i = 0; i < H; i++) begin : g_lane
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;

        assign a = (mode == BFLY_MODE_MIRROR) ? x[i]     : x[2*i];
        assign b = (mode == BFLY_MODE_MIRROR) ? x[N-1-i] : x[2*i+1];
        assign pre_sum[i]  = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        assign pre_diff[i] = {a[DATA_W-1], a} - {b[DATA_W-1], b};

        bfly_lane_scale #(.DATA_W(DATA_W), .SHIFT_W(SHIFT_W), .SAT_EN(SAT_EN)) u_sum (
            .val   (s1_sum[i]),
            .shift (s1_shift),
            .res   (sc_sum[i]),
            .ovf   (sc_ovf_s[i])
        );

        bfly_lane_scale #(.DATA_W(DATA_W), .SHIFT_W(SHIFT_W), .SAT_EN(SAT_EN)) u_diff (
            .val   (s1_diff[i]),
            .shift (s1_shift),
            .res   (sc_diff[i]),
            .ovf   (sc_ovf_d[i])
        );

        assign lane_ovf[i] = sc_ovf_s[i] | sc_ovf_d[i];
    end

    // Handshake: a beat moves across a boundary on a rising edge where the
    // sender's valid and the receiver's ready are both high; valid never waits
    // on ready, and a held output keeps its data stable until accepted.
    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_sum   <= pre_sum;
            s1_diff  <= pre_diff;
            s1_shift <= shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_diff  <= '0;
            ovf_lane  <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (s2_ready) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    for (int i = 0; i < H; i++) begin
                        out_sum[i*DATA_W +: DATA_W]  <= sc_sum[i];
                        out_diff[i*DATA_W +: DATA_W] <= sc_diff[i];
                    end
                    ovf_lane <= lane_ovf;
                end
            end
        end
    end

    // A clear wipes the prior state; an overflow delivered in the same cycle still counts.
    always_comb begin
        stat_event  = out_valid && out_ready && (|ovf_lane);
        sticky_base = ovf_clr ? 1'b0 : ovf_sticky;
        cnt_base    = ovf_clr ? '0 : ovf_count;
        cnt_next    = cnt_base;
        if (stat_event && (cnt_base != '1)) begin
            cnt_next = cnt_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end else begin
            ovf_sticky <= sticky_base | stat_event;
            ovf_count  <= cnt_next;
        end
    end

endmodule
